// File: rtl/seven_seg_multi_driver.sv
// Multi-digit seven-segment driver: latches a packed nibble word on load and drives
// registered, active-low glyphs with leading-zero blanking, per-digit blink and enables.
module seven_seg_multi_driver #(
  parameter int NUM_DIGITS = 6,
  parameter bit HEX_MODE   = 1'b0,
  parameter bit LZ_BLANK   = 1'b1,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [7*NUM_DIGITS-1:0] hex_segs,
  output logic                    bad_digit,
  output logic                    updated
);

  localparam int                CNT_W   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BLINK_DIV - 1);
  localparam logic [6:0]        SEG_BLANK = 7'b1111111;

  // Load handshake: load has no back-pressure; every cycle with load=1 is captured into
  // value_q on that edge, and updated pulses for exactly one cycle on the following edge,
  // which is the edge where hex_segs and bad_digit first reflect the new word.
  logic [4*NUM_DIGITS-1:0] value_q;
  logic                    load_pend;
  logic [CNT_W-1:0]        blink_cnt;
  logic                    blink_phase;

  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [NUM_DIGITS-1:0]   invalid;
  logic [NUM_DIGITS-1:0]   blank;
  logic [7*NUM_DIGITS-1:0] segs_next;
  logic                    bad_next;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Leading-zero scan runs on the latched word only, so disabled digits still count.
  always_comb begin
    logic seen_nz;
    seen_nz  = 1'b0;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (value_q[4*i +: 4] != 4'h0) seen_nz = 1'b1;
      lz_blank[i] = LZ_BLANK && !seen_nz && (i != 0);
    end
  end

  always_comb begin
    invalid   = '0;
    blank     = '0;
    segs_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      invalid[i] = !HEX_MODE && (value_q[4*i +: 4] > 4'd9);
      blank[i]   = !digit_en[i] || lz_blank[i] || (blink_phase && blink_mask[i]) ||
                   invalid[i];
      segs_next[7*i +: 7] = blank[i] ? SEG_BLANK : glyph(value_q[4*i +: 4]);
    end
    bad_next = |invalid;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value_q     <= '0;
      load_pend   <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      hex_segs    <= '1;
      bad_digit   <= 1'b0;
      updated     <= 1'b0;
    end else begin
      if (load) value_q <= value;
      load_pend <= load;
      updated   <= load_pend;
      hex_segs  <= segs_next;
      bad_digit <= bad_next;
      // Free-running blink timebase; the phase flips on the wrap edge.
      if (blink_cnt == CNT_MAX) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule
